// File: rtl/hls_main_pkg.sv
// Shared constants, types and FSM states for the bubble-sort kernel.
// Imported by the RAM and the top-level kernel.
package hls_main_pkg;

  localparam int N   = 100;
  localparam int DW  = 32;
  localparam int AW  = 9;
  localparam int IW  = 7;
  localparam int NCH = 2;
  localparam int LW  = 64;
  localparam int SW  = 7;

  typedef logic [DW-1:0] word_t;
  typedef word_t arr_t [N];

  localparam arr_t INIT_ARR = '{default: '0};

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_EVAL,
    S_DONE
  } state_t;

endpackage

// File: rtl/bsort_dpram.sv
// Dual-port 100x32 synchronous RAM, read-before-write.
// When both ports write one word in a cycle, port B wins.
module bsort_dpram
  import hls_main_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_we_a,
  input  logic [IW-1:0] i_addr_a,
  input  word_t         i_wdata_a,
  output word_t         o_q_a,
  input  logic          i_we_b,
  input  logic [IW-1:0] i_addr_b,
  input  word_t         i_wdata_b,
  output word_t         o_q_b
);

  word_t r_mem [N] = INIT_ARR;
  word_t r_q_a;
  word_t r_q_b;

  // Writes (B last so it wins) and registered reads
  always_ff @(posedge i_clk) begin
    if (i_we_a) r_mem[i_addr_a] <= i_wdata_a;
    if (i_we_b) r_mem[i_addr_b] <= i_wdata_b;
    r_q_a <= r_mem[i_addr_a];
    r_q_b <= r_mem[i_addr_b];
  end

  assign o_q_a = r_q_a;
  assign o_q_b = r_q_b;

endmodule

// File: rtl/hls_main.sv
// bsort100 kernel: start/done control plus two-channel slave
// port into the array, served only while idle.
module hls_main
  import hls_main_pkg::*;
#(
  parameter int MEM_var_26078_26084 = 128
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start_port,
  input  logic [NCH-1:0]      S_oe_ram,
  input  logic [NCH-1:0]      S_we_ram,
  input  logic [NCH*AW-1:0]   S_addr_ram,
  input  logic [NCH*LW-1:0]   S_Wdata_ram,
  input  logic [NCH*SW-1:0]   S_data_ram_size,
  output logic                done_port,
  output logic [NCH*LW-1:0]   Sout_Rdata_ram,
  output logic [NCH-1:0]      Sout_DataRdy
);

  localparam int          LOI   = MEM_var_26078_26084;
  localparam logic [AW:0] LO    = LOI[AW:0];
  localparam logic [AW:0] HI    = LO + (AW+1)'(N);
  localparam logic [IW-1:0] JLAST = IW'(N - 2);

  state_t        r_state, w_state_n;
  logic [IW-1:0] r_i, w_i_n;
  logic [IW-1:0] r_j, w_j_n;
  logic          r_swapped, w_sw_n;
  logic [NCH-1:0] r_rdy;
  logic [NCH-1:0] r_rdok;

  logic [AW:0]   w_off0, w_off1;
  logic [NCH-1:0] w_inwin;
  logic [IW-1:0] w_sidx0, w_sidx1;
  logic          w_busy;
  logic          w_swap;
  word_t         w_qa, w_qb;
  logic          w_we_a, w_we_b;
  logic [IW-1:0] w_addr_a, w_addr_b;
  word_t         w_wd_a, w_wd_b;
  logic          w_unused;

  // Slave address decode into the array window
  always_comb begin
    w_off0     = {1'b0, S_addr_ram[AW-1:0]} - LO;
    w_off1     = {1'b0, S_addr_ram[2*AW-1:AW]} - LO;
    w_inwin[0] = ({1'b0, S_addr_ram[AW-1:0]} >= LO) &&
                 ({1'b0, S_addr_ram[AW-1:0]} < HI);
    w_inwin[1] = ({1'b0, S_addr_ram[2*AW-1:AW]} >= LO) &&
                 ({1'b0, S_addr_ram[2*AW-1:AW]} < HI);
    w_sidx0    = w_inwin[0] ? w_off0[IW-1:0] : '0;
    w_sidx1    = w_inwin[1] ? w_off1[IW-1:0] : '0;
  end

  assign w_busy = (r_state != S_IDLE);
  assign w_swap = (r_state == S_EVAL) &&
                  ($signed(w_qa) > $signed(w_qb));

  // RAM port mux: kernel owns both ports while busy
  always_comb begin
    w_addr_a = w_busy ? r_j : w_sidx0;
    w_addr_b = w_busy ? r_j + 1'b1 : w_sidx1;
    w_we_a   = w_busy ? w_swap : (S_we_ram[0] & w_inwin[0]);
    w_we_b   = w_busy ? w_swap : (S_we_ram[1] & w_inwin[1]);
    w_wd_a   = w_busy ? w_qb : S_Wdata_ram[DW-1:0];
    w_wd_b   = w_busy ? w_qa : S_Wdata_ram[LW+DW-1:LW];
  end

  bsort_dpram u_ram (
    .i_clk     (clock),
    .i_we_a    (w_we_a),
    .i_addr_a  (w_addr_a),
    .i_wdata_a (w_wd_a),
    .o_q_a     (w_qa),
    .i_we_b    (w_we_b),
    .i_addr_b  (w_addr_b),
    .i_wdata_b (w_wd_b),
    .o_q_b     (w_qb)
  );

  // Kernel state and loop counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_i       <= '0;
      r_j       <= '0;
      r_swapped <= 1'b0;
    end else begin
      r_state   <= w_state_n;
      r_i       <= w_i_n;
      r_j       <= w_j_n;
      r_swapped <= w_sw_n;
    end
  end

  // Next state: one READ/EVAL pair per comparison
  always_comb begin
    w_state_n = r_state;
    w_i_n     = r_i;
    w_j_n     = r_j;
    w_sw_n    = r_swapped;
    unique case (r_state)
      S_IDLE: begin
        if (start_port) begin
          w_state_n = S_READ;
          w_i_n     = '0;
          w_j_n     = '0;
          w_sw_n    = 1'b0;
        end
      end
      S_READ: w_state_n = S_EVAL;
      S_EVAL: begin
        if (r_j == JLAST - r_i) begin
          if (!(r_swapped | w_swap) || r_i == JLAST) begin
            w_state_n = S_DONE;
          end else begin
            w_state_n = S_READ;
            w_i_n     = r_i + 1'b1;
            w_j_n     = '0;
            w_sw_n    = 1'b0;
          end
        end else begin
          w_state_n = S_READ;
          w_j_n     = r_j + 1'b1;
          w_sw_n    = r_swapped | w_swap;
        end
      end
      S_DONE: w_state_n = S_IDLE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // Slave acknowledge and read-valid flags, idle only
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdy  <= '0;
      r_rdok <= '0;
    end else begin
      r_rdy  <= w_busy ? '0 : (S_oe_ram | S_we_ram);
      r_rdok <= w_busy ? '0 : (S_oe_ram & w_inwin);
    end
  end

  assign done_port    = (r_state == S_DONE);
  assign Sout_DataRdy = r_rdy;
  assign Sout_Rdata_ram[LW-1:0] =
    r_rdok[0] ? {32'd0, w_qa} : '0;
  assign Sout_Rdata_ram[2*LW-1:LW] =
    r_rdok[1] ? {32'd0, w_qb} : '0;

  assign w_unused = ^{S_data_ram_size,
                      S_Wdata_ram[LW-1:DW],
                      S_Wdata_ram[2*LW-1:LW+DW],
                      w_off0[AW:IW], w_off1[AW:IW]};

endmodule

// File: tb/tb_hls_main.sv
// Directed bench for the bsort100 kernel: slave port,
// sort latency, ordering, busy behaviour and reset.
module tb_hls_main;

  logic         clock = 1'b0;
  logic         reset;
  logic         start_port;
  logic [1:0]   S_oe_ram;
  logic [1:0]   S_we_ram;
  logic [17:0]  S_addr_ram;
  logic [127:0] S_Wdata_ram;
  logic [13:0]  S_data_ram_size;
  logic         done_port;
  logic [127:0] Sout_Rdata_ram;
  logic [1:0]   Sout_DataRdy;

  int tests = 0;
  int fails = 0;

  logic signed [31:0] buf_a [100];
  logic signed [31:0] rd_a  [100];
  logic signed [31:0] exp_a [100];

  hls_main #(.MEM_var_26078_26084(128)) dut (
    .clock           (clock),
    .reset           (reset),
    .start_port      (start_port),
    .S_oe_ram        (S_oe_ram),
    .S_we_ram        (S_we_ram),
    .S_addr_ram      (S_addr_ram),
    .S_Wdata_ram     (S_Wdata_ram),
    .S_data_ram_size (S_data_ram_size),
    .done_port       (done_port),
    .Sout_Rdata_ram  (Sout_Rdata_ram),
    .Sout_DataRdy    (Sout_DataRdy)
  );

  always #5 clock = ~clock;

  task automatic load_buf();
    for (int k = 0; k < 100; k += 2) begin
      @(negedge clock);
      S_we_ram    = 2'b11;
      S_addr_ram  = {9'(128 + k + 1), 9'(128 + k)};
      S_Wdata_ram = {32'd0, buf_a[k+1], 32'd0, buf_a[k]};
    end
    @(negedge clock);
    S_we_ram = 2'b00;
  endtask

  task automatic read_all();
    for (int k = 0; k < 100; k += 2) begin
      @(negedge clock);
      S_oe_ram   = 2'b11;
      S_addr_ram = {9'(128 + k + 1), 9'(128 + k)};
      @(negedge clock);
      rd_a[k]   = Sout_Rdata_ram[31:0];
      rd_a[k+1] = Sout_Rdata_ram[95:64];
      S_oe_ram  = 2'b00;
    end
  endtask

  task automatic check_arr(input string name);
    int bad = 0;
    int first = -1;
    for (int k = 0; k < 100; k++) begin
      if (rd_a[k] !== exp_a[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL %s: %0d words differ, idx %0d got %0d want %0d",
               name, bad, first, rd_a[first], exp_a[first]);
    end
  endtask

  // Reference bubble sort with early exit; returns comparisons
  function automatic int model_sort();
    int comps = 0;
    logic signed [31:0] t;
    bit sw;
    for (int k = 0; k < 100; k++) exp_a[k] = buf_a[k];
    for (int i = 0; i < 99; i++) begin
      sw = 1'b0;
      for (int j = 0; j <= 98 - i; j++) begin
        comps++;
        if (exp_a[j] > exp_a[j+1]) begin
          t = exp_a[j];
          exp_a[j] = exp_a[j+1];
          exp_a[j+1] = t;
          sw = 1'b1;
        end
      end
      if (!sw) break;
    end
    return comps;
  endfunction

  // Start pulse at cycle 0; returns the cycle done_port is seen.
  // inj>0 injects start and slave strobes while busy at cycle inj.
  task automatic run_sort(input int inj, output int dcyc);
    int n = 0;
    dcyc = -1;
    @(negedge clock);
    start_port = 1'b1;
    while (n < 12000) begin
      @(negedge clock);
      n++;
      start_port = 1'b0;
      if (done_port === 1'b1) begin
        dcyc = n;
        break;
      end
      if (inj > 0 && n == inj) begin
        start_port  = 1'b1;
        S_oe_ram    = 2'b01;
        S_we_ram    = 2'b10;
        S_addr_ram  = {9'd133, 9'd128};
        S_Wdata_ram = {32'd0, 32'd999, 64'd0};
      end
      if (inj > 0 && n == inj + 1) begin
        S_oe_ram = 2'b00;
        S_we_ram = 2'b00;
        tests++;
        if (Sout_DataRdy !== 2'b00) begin
          fails++;
          $display("FAIL busy_ack: got %b want 00", Sout_DataRdy);
        end
      end
    end
    start_port = 1'b0;
    if (dcyc < 0)
      $display("FAIL sort_timeout: no done within 12000 cycles");
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    tests++;
    if (done_port !== 1'b0) begin
      fails++;
      $display("FAIL rst_done: got %b want 0", done_port);
    end
    tests++;
    if (Sout_DataRdy !== 2'b00) begin
      fails++;
      $display("FAIL rst_rdy: got %b want 00", Sout_DataRdy);
    end
    tests++;
    if (Sout_Rdata_ram !== 128'd0) begin
      fails++;
      $display("FAIL rst_rdata: got %h want 0", Sout_Rdata_ram);
    end
  endtask

  task automatic test_slave();
    @(negedge clock);
    S_we_ram    = 2'b01;
    S_addr_ram  = {9'd0, 9'd128};
    S_Wdata_ram = {64'd0, 32'd0, 32'hDEADBEEF};
    @(negedge clock);
    tests++;
    if (Sout_DataRdy !== 2'b01) begin
      fails++;
      $display("FAIL wr0_ack: got %b want 01", Sout_DataRdy);
    end
    S_we_ram    = 2'b10;
    S_addr_ram  = {9'd227, 9'd0};
    S_Wdata_ram = {32'd0, 32'hFFFFFFFB, 64'd0};
    @(negedge clock);
    tests++;
    if (Sout_DataRdy !== 2'b10) begin
      fails++;
      $display("FAIL wr1_ack: got %b want 10", Sout_DataRdy);
    end
    S_we_ram = 2'b00;
    @(negedge clock);
    tests++;
    if (Sout_DataRdy !== 2'b00) begin
      fails++;
      $display("FAIL ack_pulse: got %b want 00", Sout_DataRdy);
    end
    S_oe_ram   = 2'b11;
    S_addr_ram = {9'd227, 9'd128};
    @(negedge clock);
    tests++;
    if (Sout_Rdata_ram !== 128'h00000000FFFFFFFB_00000000DEADBEEF) begin
      fails++;
      $display("FAIL rd_both: got %h", Sout_Rdata_ram);
    end
    tests++;
    if (Sout_DataRdy !== 2'b11) begin
      fails++;
      $display("FAIL rd_ack: got %b want 11", Sout_DataRdy);
    end
    S_oe_ram   = 2'b01;
    S_addr_ram = {9'd0, 9'd300};
    @(negedge clock);
    tests++;
    if (Sout_Rdata_ram[63:0] !== 64'd0 || Sout_DataRdy !== 2'b01) begin
      fails++;
      $display("FAIL rd_oow: got %h/%b want 0/01",
               Sout_Rdata_ram[63:0], Sout_DataRdy);
    end
    S_oe_ram    = 2'b00;
    S_we_ram    = 2'b11;
    S_addr_ram  = {9'd130, 9'd130};
    S_Wdata_ram = {32'd0, 32'd222, 32'd0, 32'd111};
    @(negedge clock);
    S_we_ram    = 2'b01;
    S_addr_ram  = {9'd0, 9'd127};
    S_Wdata_ram = {64'd0, 32'd0, 32'd77};
    @(negedge clock);
    S_we_ram   = 2'b00;
    S_oe_ram   = 2'b11;
    S_addr_ram = {9'd130, 9'd128};
    @(negedge clock);
    tests++;
    if (Sout_Rdata_ram[63:0] !== 64'h00000000DEADBEEF) begin
      fails++;
      $display("FAIL oow_wr: got %h want deadbeef",
               Sout_Rdata_ram[63:0]);
    end
    tests++;
    if (Sout_Rdata_ram[127:64] !== 64'd222) begin
      fails++;
      $display("FAIL ch1_wins: got %0d want 222",
               Sout_Rdata_ram[127:64]);
    end
    S_oe_ram = 2'b00;
  endtask

  task automatic test_presorted();
    int d;
    for (int k = 0; k < 100; k++) buf_a[k] = k;
    load_buf();
    run_sort(100, d);
    tests++;
    if (d != 199) begin
      fails++;
      $display("FAIL presorted_cyc: got %0d want 199", d);
    end
    @(negedge clock);
    tests++;
    if (done_port !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: got %b want 0", done_port);
    end
    for (int k = 0; k < 100; k++) exp_a[k] = k;
    read_all();
    check_arr("presorted_arr");
  endtask

  task automatic test_reversed();
    int d;
    for (int k = 0; k < 100; k++) buf_a[k] = 99 - k;
    load_buf();
    run_sort(0, d);
    tests++;
    if (d != 9901) begin
      fails++;
      $display("FAIL reversed_cyc: got %0d want 9901", d);
    end
    for (int k = 0; k < 100; k++) exp_a[k] = k;
    read_all();
    check_arr("reversed_arr");
  endtask

  task automatic test_mixed();
    int d;
    int c;
    buf_a[0] = 5;
    buf_a[1] = -3;
    buf_a[2] = 5;
    buf_a[3] = 32'h80000000;
    buf_a[4] = 32'h7FFFFFFF;
    buf_a[5] = 0;
    buf_a[6] = -1;
    for (int k = 7; k < 100; k++) buf_a[k] = ((k * 37) % 23) - 11;
    c = model_sort();
    load_buf();
    run_sort(0, d);
    tests++;
    if (d != 1 + 2 * c || d > 9901) begin
      fails++;
      $display("FAIL mixed_cyc: got %0d want %0d", d, 1 + 2 * c);
    end
    read_all();
    tests++;
    if (rd_a[0] !== 32'h80000000) begin
      fails++;
      $display("FAIL mixed_min: got %h want 80000000", rd_a[0]);
    end
    tests++;
    if (rd_a[99] !== 32'h7FFFFFFF) begin
      fails++;
      $display("FAIL mixed_max: got %h want 7fffffff", rd_a[99]);
    end
    check_arr("mixed_arr");
  endtask

  task automatic test_reset_mid();
    int d;
    bit seen = 1'b0;
    for (int k = 0; k < 100; k++) buf_a[k] = 99 - k;
    load_buf();
    @(negedge clock);
    start_port = 1'b1;
    for (int n = 1; n <= 260; n++) begin
      @(negedge clock);
      start_port = (n == 20);
      reset      = (n == 50);
      if (done_port === 1'b1) seen = 1'b1;
    end
    start_port = 1'b0;
    reset      = 1'b0;
    tests++;
    if (seen) begin
      fails++;
      $display("FAIL mid_reset_done: got pulse want none");
    end
    run_sort(0, d);
    tests++;
    if (d < 0 || d > 9901) begin
      fails++;
      $display("FAIL restart_cyc: got %0d want 1..9901", d);
    end
    for (int k = 0; k < 100; k++) exp_a[k] = k;
    read_all();
    check_arr("restart_arr");
  endtask

  initial begin
    reset           = 1'b1;
    start_port      = 1'b0;
    S_oe_ram        = '0;
    S_we_ram        = '0;
    S_addr_ram      = '0;
    S_Wdata_ram     = '0;
    S_data_ram_size = {7'd32, 7'd32};
    test_reset();
    test_slave();
    test_presorted();
    test_reversed();
    test_mixed();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
